// File: rtl/score_accum_if.sv
`timescale 1ns/1ps
// score_accum_if: bundle between collision/round control and the score accumulator.
//   clr        round clear pulse (master -> slave)
//   snowf_get  per-flake collected level flags (master -> slave)
//   score      running round score (slave -> master)
//   best       best score since reset (slave -> master)
//   gained     flakes credited in the last update (slave -> master)
//   score_upd  one-cycle pulse when score was updated (slave -> master)
//   all_got    every flake credited this round (slave -> master)
//   sat        score clipped at the ceiling this round (slave -> master)
interface score_accum_if #(
    parameter int unsigned N_FLAKES = 15,
    parameter int unsigned SCORE_W  = 8,
    parameter int unsigned CNT_W    = $clog2(N_FLAKES + 1)
);
    logic                clr;
    logic [N_FLAKES-1:0] snowf_get;
    logic [SCORE_W-1:0]  score;
    logic [SCORE_W-1:0]  best;
    logic [CNT_W-1:0]    gained;
    logic                score_upd;
    logic                all_got;
    logic                sat;

    modport master (
        output clr, snowf_get,
        input  score, best, gained, score_upd, all_got, sat
    );

    modport slave (
        input  clr, snowf_get,
        output score, best, gained, score_upd, all_got, sat
    );
endinterface

// File: rtl/score_accum.sv
`timescale 1ns/1ps
// score_accum: credits each snowflake at most once per round, keeps a
// saturating round score and a best score across rounds.
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    score_accum_if slave (clr, snowf_get in; score, best, gained,
//          score_upd, all_got, sat out)
module score_accum #(
    parameter int unsigned N_FLAKES  = 15,
    parameter int unsigned SCORE_W   = 8,
    parameter int unsigned MAX_SCORE = 255,
    parameter int unsigned CNT_W     = $clog2(N_FLAKES + 1)
) (
    input  logic         clk,
    input  logic         rst_n,
    score_accum_if.slave bus
);

    // Sum width covers both operands so a wide hit count cannot wrap.
    localparam int unsigned SUM_W = ((SCORE_W > CNT_W) ? SCORE_W : CNT_W) + 1;

    logic [N_FLAKES-1:0] got;
    logic [N_FLAKES-1:0] new_flags_c;
    logic [CNT_W-1:0]    hits_c;
    logic [CNT_W-1:0]    hits_q;
    logic                hv_q;

    logic [SCORE_W-1:0]  score;
    logic [SCORE_W-1:0]  best;
    logic [CNT_W-1:0]    gained;
    logic                score_upd;
    logic                sat;

    logic [SUM_W-1:0]    sum_c;
    logic                ovf_c;
    logic [SCORE_W-1:0]  score_nxt_c;

    // Flags not yet credited this round, and how many of them there are.
    always_comb begin
        new_flags_c = bus.snowf_get & ~got;
        hits_c      = '0;
        for (int unsigned i = 0; i < N_FLAKES; i++) begin
            hits_c = hits_c + CNT_W'(new_flags_c[i]);
        end
    end

    // Saturating add of the staged hit count.
    always_comb begin
        sum_c       = SUM_W'(score) + SUM_W'(hits_q);
        ovf_c       = sum_c > SUM_W'(MAX_SCORE);
        score_nxt_c = ovf_c ? SCORE_W'(MAX_SCORE) : SCORE_W'(sum_c);
    end

    // Stage 1: mark credited flakes and register the hit count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            got    <= '0;
            hits_q <= '0;
            hv_q   <= 1'b0;
        end else if (bus.clr) begin
            got    <= '0;
            hits_q <= '0;
            hv_q   <= 1'b0;
        end else begin
            got    <= got | new_flags_c;
            hits_q <= hits_c;
            hv_q   <= |new_flags_c;
        end
    end

    // Stage 2: apply the staged hits to score/best; best survives clr.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            score     <= '0;
            best      <= '0;
            gained    <= '0;
            score_upd <= 1'b0;
            sat       <= 1'b0;
        end else if (bus.clr) begin
            score     <= '0;
            gained    <= '0;
            score_upd <= 1'b0;
            sat       <= 1'b0;
        end else if (hv_q) begin
            score     <= score_nxt_c;
            gained    <= hits_q;
            score_upd <= 1'b1;
            sat       <= sat | ovf_c;
            if (score_nxt_c > best) begin
                best <= score_nxt_c;
            end
        end else begin
            score_upd <= 1'b0;
        end
    end

    assign bus.score     = score;
    assign bus.best      = best;
    assign bus.gained    = gained;
    assign bus.score_upd = score_upd;
    assign bus.sat       = sat;
    assign bus.all_got   = &got;

endmodule
